// File: rtl/coin_change_dispenser_pkg.sv
// coin_change_dispenser_pkg: coin count, stock width and FSM states shared by the dispenser.
// Stock width is only present when COIN_INVENTORY_EN is defined.
package coin_change_dispenser_pkg;
    localparam int NUM_COINS = 3;
`ifdef COIN_INVENTORY_EN
    localparam int INV_W = 8;
`endif
    typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;
endpackage

// File: rtl/coin_change_dispenser_coin_select.sv
// coin_change_dispenser_coin_select: greedy picker of the largest coin not exceeding the balance.
module coin_change_dispenser_coin_select
    import coin_change_dispenser_pkg::*;
#(
    parameter int TOTAL_W    = 32,
    parameter int COIN_VAL_0 = 100,
    parameter int COIN_VAL_1 = 500,
    parameter int COIN_VAL_2 = 1000
) (
    input  logic [TOTAL_W-1:0]   balance_i,
    input  logic [NUM_COINS-1:0] empty_i,
    output logic [NUM_COINS-1:0] onehot_o,
    output logic                 found_o
);
    logic [NUM_COINS-1:0] ok;
    assign ok = {balance_i >= TOTAL_W'(COIN_VAL_2) && !empty_i[2],
                 balance_i >= TOTAL_W'(COIN_VAL_1) && !empty_i[1],
                 balance_i >= TOTAL_W'(COIN_VAL_0) && !empty_i[0]};
    assign onehot_o = ok[2] ? 3'b100 : ok[1] ? 3'b010 : ok[0] ? 3'b001 : 3'b000;
    assign found_o  = |ok;
endmodule

// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: breaks a return amount into coins, largest first, over a valid/ack hopper handshake.
// Define COIN_INVENTORY_EN for per-coin stock counters that limit selection.
module coin_change_dispenser
    import coin_change_dispenser_pkg::*;
#(
    parameter int TOTAL_W     = 32,
    parameter int COIN_VAL_0  = 100,
    parameter int COIN_VAL_1  = 500,
    parameter int COIN_VAL_2  = 1000,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_return_req,
    input  logic [TOTAL_W-1:0]   i_return_total,
    output logic                 o_busy,
    output logic                 o_coin_valid,
    output logic [NUM_COINS-1:0] o_coin_type,
    input  logic                 i_coin_ack,
    output logic                 o_done,
    output logic [TOTAL_W-1:0]   o_remainder,
    output logic                 o_err
`ifdef COIN_INVENTORY_EN
    ,
    input  logic                       i_inv_load,
    input  logic [NUM_COINS*INV_W-1:0] i_inv_count,
    output logic [NUM_COINS-1:0]       o_inv_empty
`endif
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    state_t               state_q;
    logic [TOTAL_W-1:0]   bal_q, rem_q, coin_val;
    logic [TW-1:0]        tmo_q;
    logic                 busy_q, valid_q, done_q, err_q, found;
    logic [NUM_COINS-1:0] type_q, pick, empty;
`ifdef COIN_INVENTORY_EN
    logic [INV_W-1:0] cnt_q [NUM_COINS];
    for (genvar k = 0; k < NUM_COINS; k++) begin : g_empty
        assign empty[k] = cnt_q[k] == '0;
    end
    assign o_inv_empty = empty;
`else
    assign empty = '0;
`endif
    coin_change_dispenser_coin_select #(
        .TOTAL_W(TOTAL_W), .COIN_VAL_0(COIN_VAL_0), .COIN_VAL_1(COIN_VAL_1), .COIN_VAL_2(COIN_VAL_2)
    ) u_sel (
        .balance_i(bal_q), .empty_i(empty), .onehot_o(pick), .found_o(found)
    );
    assign coin_val = type_q[2] ? TOTAL_W'(COIN_VAL_2) : type_q[1] ? TOTAL_W'(COIN_VAL_1) : TOTAL_W'(COIN_VAL_0);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bal_q   <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= '0;
`ifdef COIN_INVENTORY_EN
            cnt_q   <= '{default: '0};
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_return_req) begin
                        bal_q   <= i_return_total;
                        busy_q  <= 1'b1;
                        state_q <= SELECT;
                    end
`ifdef COIN_INVENTORY_EN
                    if (i_inv_load)
                        for (int k = 0; k < NUM_COINS; k++) cnt_q[k] <= i_inv_count[k*INV_W +: INV_W];
`endif
                end
                SELECT: begin
                    if (found) begin
                        valid_q <= 1'b1;
                        type_q  <= pick;
                        tmo_q   <= '0;
                        state_q <= OFFER;
                    end else begin
                        done_q  <= 1'b1;
                        rem_q   <= bal_q;
                        state_q <= DONE;
                    end
                end
                OFFER: begin
                    if (i_coin_ack) begin
                        bal_q   <= bal_q - coin_val;
                        valid_q <= 1'b0;
                        type_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= SELECT;
`ifdef COIN_INVENTORY_EN
                        for (int k = 0; k < NUM_COINS; k++)
                            if (type_q[k]) cnt_q[k] <= cnt_q[k] - 1'b1;
`endif
                    end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                        // hopper stalled: abandon the coin, keep the balance as remainder
                        valid_q <= 1'b0;
                        type_q  <= '0;
                        tmo_q   <= '0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rem_q   <= bal_q;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_busy       = busy_q;
    assign o_coin_valid = valid_q;
    assign o_coin_type  = type_q;
    assign o_done       = done_q;
    assign o_remainder  = rem_q;
    assign o_err        = err_q;
endmodule
